dw_fp_sum4_seq: RTL and testbench
=================================

Name: dw_fp_sum4_seq

Overview:
Streaming reduction sequencer around a single DW_fp_sum4 instance. It sums a run of `len` IEEE floating-point operands arriving one per beat on a valid/ready stream. Operands are folded three at a time into a registered accumulator, with the accumulator itself as the fourth sum4 input. It sits between an operand FIFO and a result consumer in FP datapaths that need vector sums but can afford only one 4-input adder.

Parameters:
sig_width, 23, significand width passed to DW_fp_sum4
exp_width, 8, exponent width passed to DW_fp_sum4
ieee_compliance, 0, passed to DW_fp_sum4
arch_type, 0, passed to DW_fp_sum4
len_width, 8, width of the operand-count input

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a reduction; accepted only in IDLE
len  in  len_width  operand count, sampled with start
rnd  in  3  DW rounding mode, sampled with start, held for the whole run
busy  out  1  high in every state except IDLE
in_valid  in  1  operand beat valid
in_data  in  sig_width+exp_width+1  operand
in_ready  out  1  high only in LOAD
out_valid  out  1  result valid, high only in DONE
out_data  out  sig_width+exp_width+1  final sum
out_status  out  8  DW status of the reduction
out_ready  in  1  result consumer ready

Behaviour:
- Reset, asynchronous, active-low, mid-operation included: state=IDLE. busy, in_ready, out_valid, out_data, out_status, accumulator, slots, counters and sticky status all 0. Any run in progress is abandoned with no output.
- States:
  - IDLE -> LOAD on start with len!=0.
  - IDLE -> DONE on start with len==0.
  - LOAD -> FIRE when the slot count reaches 3 or remaining reaches 0.
  - FIRE -> LOAD if remaining!=0, else DONE.
  - DONE -> IDLE on out_ready.
- On start: rnd_q<=rnd, remaining<=len, acc<=+0 (all zeros), slots<=+0, slot_cnt<=0, sticky<=0.
- LOAD: a beat transfers on in_valid&&in_ready. Each transfer writes slot[slot_cnt], increments slot_cnt and decrements remaining. No bubble is required between beats.
- FIRE (one cycle):
  - DW_fp_sum4 is combinational with a=acc, b=slot0, c=slot1, d=slot2, rnd=rnd_q.
  - acc<=z; last_status<=status; sticky[7:2] |= status[7:2].
  - All slots are reset to +0 and slot_cnt<=0. Unfilled slots of a short final group are therefore +0.
- out_data = acc.
- out_status = {sticky[7:2] | last_status[7:2], last_status[1:0]}. Bits 0 (zero) and 1 (infinity) reflect the final addition only.
- len==0: out_data=+0, out_status=8'h01.
- Padding or the initial accumulator of +0 may turn an exact -0 result into +0 (rnd!=3'b011). This is accepted behaviour.
- Latency with in_valid continuously high: out_valid asserts 1+len+ceil(len/3) cycles after the start cycle. Gaps in in_valid add one cycle each.
- DONE: out_valid, out_data and out_status are held stable until out_ready; the transfer cycle returns to IDLE. start in the same cycle as the out transfer is ignored.
- start while busy: ignored, no effect on the run.
- in_valid outside LOAD: ignored; in_ready=0.
- len=2^len_width-1 must work; remaining never underflows.
- The internal operand registers match the DW width sig_width+exp_width+1.

Decomposition:
- Package dw_fp_sum4_seq_pkg:
  - state enum (IDLE, LOAD, FIRE, DONE)
  - status bit index constants (ZERO=0, INF=1, INVALID=2, TINY=3, HUGE=4, INEXACT=5, HUGEINT=6, COMPSPEC=7)
  - STICKY_MASK=8'hFC
  - function returning +0 for a given width
- Sole sub-module: one DW_fp_sum4 instance with parameters passed through. No further hierarchy.

Test Plan:
- len=3, rnd=0, operands 32'h3F800000, 32'h40000000, 32'h40400000 with continuous valid -> out_data 32'h40C00000 (6.0), out_status 8'h00, out_valid 5 cycles after start.
- len=5, five beats of 32'h3F800000 -> two FIREs (second padded with one +0), out_data 32'h40A00000 (5.0), out_valid at cycle 8.
- len=0 -> out_valid next cycle, out_data 32'h00000000, out_status 8'h01, in_ready never asserted.
- len=4: 32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h3F800000 -> out_status[2] (invalid) =1. The bit remains set although the second FIRE alone does not raise it.
- Hold out_ready=0 for 4 cycles in DONE with start pulsed -> out_valid and out_data stable, start ignored; the out transfer on cycle 5 returns busy to 0.
- Deassert rst_n after 2 accepted beats of a len=6 run -> busy, in_ready and out_valid drop immediately. A fresh len=3 run then returns 6.0 with no residue.

Source files
------------

// File: rtl/dw_fp_sum4_seq_pkg.sv
// Shared types and constants for the sum4 reduction sequencer.
// Also holds the status bit map of the 4-input FP adder.
package dw_fp_sum4_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_DONE
  } state_e;

  localparam int ST_ZERO     = 0;
  localparam int ST_INF      = 1;
  localparam int ST_INVALID  = 2;
  localparam int ST_TINY     = 3;
  localparam int ST_HUGE     = 4;
  localparam int ST_INEXACT  = 5;
  localparam int ST_HUGEINT  = 6;
  localparam int ST_COMPSPEC = 7;

  localparam logic [7:0] STICKY_MASK = 8'hFC;

  localparam int FP_MAX_W = 128;

  // Signed zero of width w; neg=0 gives +0 (all zeros).
  function automatic logic [FP_MAX_W-1:0] fp_signed_zero(
    input logic        neg,
    input int unsigned w
  );
    fp_signed_zero = {{(FP_MAX_W-1){1'b0}}, neg} << (w - 1);
  endfunction

endpackage

// File: rtl/DW_fp_sum4.sv
// Combinational 4-operand FP adder: align to the largest exponent,
// sum exactly with guard/sticky bits, normalise, round once.
module DW_fp_sum4
  import dw_fp_sum4_seq_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int arch_type       = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [sig_width+exp_width:0] c,
  input  logic [sig_width+exp_width:0] d,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int S    = sig_width;
  localparam int E    = exp_width;
  localparam int W    = S + E + 1;
  localparam int G    = S + 3;
  localparam int X    = S + 1 + G;
  localparam int M    = X + 2;
  localparam int SW   = M + 1;
  localparam int EMAX = (1 << E) - 1;

  logic [W-1:0]          op   [4];
  logic [E-1:0]          eff  [4];
  logic [S:0]            mnt  [4];
  logic signed [SW-1:0]  term [4];
  logic [3:0]            sgn, is_inf, is_nan;
  logic [E-1:0]          emax;
  logic signed [SW-1:0]  sum;
  logic [M-1:0]          mag, norm;
  logic [S:0]            mant;
  logic [S+1:0]          mr;
  logic                  sign_r, rb, st, inc, tomax;
  int                    lz, er;

  function automatic logic [X-1:0] align(
    input logic [S:0]   m,
    input logic [E-1:0] sh
  );
    logic [2*X-1:0] t;
    t = {m, {(2*X-S-1){1'b0}}} >> sh;
    if (int'(sh) >= X) align = {{(X-1){1'b0}}, |m};
    else align = {t[2*X-1:X+1], t[X] | (|t[X-1:0])};
  endfunction

  always_comb begin
    op[0] = a;
    op[1] = b;
    op[2] = c;
    op[3] = d;
    emax  = '0;
    for (int i = 0; i < 4; i++) begin
      sgn[i]    = op[i][W-1];
      is_inf[i] = (&op[i][W-2:S]) &&
                  (ieee_compliance == 0 || op[i][S-1:0] == '0);
      is_nan[i] = (&op[i][W-2:S]) && !is_inf[i];
      if (op[i][W-2:S] == '0) begin
        eff[i] = {{(E-1){1'b0}}, 1'b1};
        mnt[i] = (ieee_compliance != 0) ? {1'b0, op[i][S-1:0]} : '0;
      end else begin
        eff[i] = op[i][W-2:S];
        mnt[i] = {1'b1, op[i][S-1:0]};
      end
      if (eff[i] > emax) emax = eff[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      term[i] = $signed({3'b000, align(mnt[i], emax - eff[i])});
      if (sgn[i]) term[i] = -term[i];
    end
  end

  // Both shapes form the same exact integer sum.
  if (arch_type == 0) begin : g_tree
    assign sum = (term[0] + term[1]) + (term[2] + term[3]);
  end else begin : g_chain
    assign sum = ((term[0] + term[1]) + term[2]) + term[3];
  end

  always_comb begin
    sign_r = sum[SW-1];
    mag    = M'(sign_r ? -sum : sum);
    lz     = M;
    for (int i = 0; i < M; i++)
      if (mag[i]) lz = M - 1 - i;
    norm = mag << lz;
    er   = int'(emax) + 2 - lz;
    mant = norm[M-1 -: S+1];
    rb   = norm[M-S-2];
    st   = |norm[M-S-3:0];
    unique case (rnd)
      3'd0:    inc = rb & (st | mant[0]);
      3'd2:    inc = !sign_r & (rb | st);
      3'd3:    inc = sign_r & (rb | st);
      3'd4:    inc = rb;
      3'd5:    inc = rb | st;
      default: inc = 1'b0;
    endcase
    mr = {1'b0, mant} + {{(S+1){1'b0}}, inc};
    if (mr[S+1]) begin
      er = er + 1;
      mr = mr >> 1;
    end
    tomax = (rnd == 3'd1) || (rnd == 3'd2 && sign_r) ||
            (rnd == 3'd3 && !sign_r);
  end

  always_comb begin
    z      = '0;
    status = '0;
    status[ST_HUGEINT]  = 1'b0;
    status[ST_COMPSPEC] = 1'b0;
    if ((|is_nan) || ((|(is_inf & sgn)) && (|(is_inf & ~sgn)))) begin
      status[ST_INVALID] = 1'b1;
      status[ST_INF]     = (ieee_compliance == 0);
      z = {1'b0, {E{1'b1}}, S'(ieee_compliance != 0)};
    end else if (|is_inf) begin
      status[ST_INF] = 1'b1;
      z = {|(is_inf & sgn), {E{1'b1}}, {S{1'b0}}};
    end else if (mag == '0) begin
      status[ST_ZERO] = 1'b1;
      z = W'(fp_signed_zero(rnd == 3'd3, W));
    end else if (er <= 0 || !mr[S]) begin
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      z = W'(fp_signed_zero(sign_r, W));
    end else if (er >= EMAX) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      if (tomax) begin
        z = {sign_r, E'(EMAX - 1), {S{1'b1}}};
      end else begin
        status[ST_INF] = 1'b1;
        z = {sign_r, {E{1'b1}}, {S{1'b0}}};
      end
    end else begin
      status[ST_INEXACT] = rb | st;
      z = {sign_r, E'(er), mr[S-1:0]};
    end
  end

endmodule

// File: rtl/dw_fp_sum4_seq.sv
// Streaming FP vector sum: folds three operands per FIRE into an
// accumulator that feeds back as the fourth adder input.
module dw_fp_sum4_seq
  import dw_fp_sum4_seq_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0,
  parameter int arch_type       = 0,
  parameter int len_width       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [len_width-1:0]         len,
  input  logic [2:0]                   rnd,
  output logic                         busy,
  input  logic                         in_valid,
  input  logic [sig_width+exp_width:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [sig_width+exp_width:0] out_data,
  output logic [7:0]                   out_status,
  input  logic                         out_ready
);

  localparam int W = sig_width + exp_width + 1;

  state_e               state_q, state_d;
  logic [2:0]           rnd_q;
  logic [len_width-1:0] rem_q;
  logic [W-1:0]         acc_q, s0_q, s1_q, s2_q;
  logic [W-1:0]         zero_w, sum_z;
  logic [1:0]           cnt_q;
  logic [7:0]           sticky_q, last_q, sum_st;
  logic                 busy_q, in_ready_q, out_valid_q;
  logic                 beat;

  assign zero_w     = W'(fp_signed_zero(1'b0, W));
  assign beat       = in_valid && in_ready_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = acc_q;
  assign out_status = (sticky_q & STICKY_MASK) | last_q;

  DW_fp_sum4 #(
    .sig_width      (sig_width),
    .exp_width      (exp_width),
    .ieee_compliance(ieee_compliance),
    .arch_type      (arch_type)
  ) u_sum4 (
    .a     (acc_q),
    .b     (s0_q),
    .c     (s1_q),
    .d     (s2_q),
    .rnd   (rnd_q),
    .z     (sum_z),
    .status(sum_st)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = (len == '0) ? S_DONE : S_LOAD;
      S_LOAD:
        if (beat && (cnt_q == 2'd2 || rem_q == len_width'(1)))
          state_d = S_FIRE;
      S_FIRE:
        state_d = (rem_q != '0) ? S_LOAD : S_DONE;
      S_DONE:
        if (out_ready) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rnd_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      cnt_q       <= '0;
      sticky_q    <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_DONE);
      unique case (state_q)
        S_IDLE:
          if (start) begin
            rnd_q    <= rnd;
            rem_q    <= len;
            acc_q    <= zero_w;
            s0_q     <= zero_w;
            s1_q     <= zero_w;
            s2_q     <= zero_w;
            cnt_q    <= '0;
            sticky_q <= '0;
            // An empty run reports an exact zero.
            last_q   <= (len == '0) ? 8'h01 : 8'h00;
          end
        S_LOAD:
          if (beat) begin
            unique case (cnt_q)
              2'd0:    s0_q <= in_data;
              2'd1:    s1_q <= in_data;
              default: s2_q <= in_data;
            endcase
            cnt_q <= cnt_q + 2'd1;
            rem_q <= rem_q - len_width'(1);
          end
        S_FIRE: begin
          acc_q    <= sum_z;
          last_q   <= sum_st;
          sticky_q <= sticky_q | (sum_st & STICKY_MASK);
          s0_q     <= zero_w;
          s1_q     <= zero_w;
          s2_q     <= zero_w;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dw_fp_sum4_seq.sv
// Directed bench for dw_fp_sum4_seq with hand-computed sums,
// latencies and status flags.
module tb_dw_fp_sum4_seq;

  localparam int W  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [2:0]    rnd = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [7:0]    out_status;
  logic          out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ops [256];
  logic [W-1:0] res_data;
  logic [7:0]   res_status;
  int           res_lat;
  bit           saw_ready;

  always #5 clk = ~clk;

  dw_fp_sum4_seq #(
    .sig_width      (23),
    .exp_width      (8),
    .ieee_compliance(0),
    .arch_type      (0),
    .len_width      (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .rnd       (rnd),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_status(out_status),
    .out_ready (out_ready)
  );

  task automatic do_run(input int n, input logic [2:0] r,
                        input int gap_cyc, input bit hold,
                        input bit restart);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    res_lat = -1;
    saw_ready = 0;
    out_ready = !hold;
    start = 1'b1;
    len = LW'(n);
    rnd = r;
    in_valid = 1'b0;
    while (res_lat < 0 && cyc < 600) begin
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
      start = restart;
      if (restart) len = '0;
      if (in_ready) saw_ready = 1;
      if (out_valid) begin
        res_lat = cyc;
        res_data = out_data;
        res_status = out_status;
      end
      in_valid = (idx < n) && (cyc != gap_cyc);
      in_data = ops[(idx < 256) ? idx : 0];
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (res_lat < 0) begin
      errors++;
      $display("FAIL run_timeout n=%0d: no out_valid, required within 600 cycles", n);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b in_ready=%b out_valid=%b required 000",
               busy, in_ready, out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 00000000", out_data);
    end
    checks++;
    if (out_status !== 8'h00) begin
      errors++;
      $display("FAIL reset_status got %h required 00", out_status);
    end
  endtask

  task automatic test_sum3();
    ops[0] = 32'h3F800000;
    ops[1] = 32'h40000000;
    ops[2] = 32'h40400000;
    do_run(3, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 5) begin
      errors++;
      $display("FAIL sum3_latency got %0d required 5", res_lat);
    end
    checks++;
    if (res_data !== 32'h40C00000) begin
      errors++;
      $display("FAIL sum3_data got %h required 40c00000", res_data);
    end
    checks++;
    if (res_status !== 8'h00) begin
      errors++;
      $display("FAIL sum3_status got %h required 00", res_status);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sum3_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_padded_groups();
    for (int i = 0; i < 5; i++) ops[i] = 32'h3F800000;
    do_run(5, 3'd0, -1, 0, 1);
    checks++;
    if (res_lat !== 8) begin
      errors++;
      $display("FAIL len5_latency got %0d required 8", res_lat);
    end
    checks++;
    if (res_data !== 32'h40A00000) begin
      errors++;
      $display("FAIL len5_data got %h required 40a00000", res_data);
    end
    checks++;
    if (res_status !== 8'h00) begin
      errors++;
      $display("FAIL len5_status got %h required 00", res_status);
    end
  endtask

  task automatic test_len_zero();
    do_run(0, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 1) begin
      errors++;
      $display("FAIL len0_latency got %0d required 1", res_lat);
    end
    checks++;
    if (res_data !== 32'h0 || res_status !== 8'h01) begin
      errors++;
      $display("FAIL len0_result got %h/%h required 00000000/01",
               res_data, res_status);
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL len0_in_ready got 1 required never asserted");
    end
  endtask

  task automatic test_invalid_sticky();
    ops[0] = 32'h7F800000;
    ops[1] = 32'hFF800000;
    ops[2] = 32'h3F800000;
    ops[3] = 32'h3F800000;
    do_run(4, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 7) begin
      errors++;
      $display("FAIL invalid_latency got %0d required 7", res_lat);
    end
    checks++;
    if (res_status[2] !== 1'b1) begin
      errors++;
      $display("FAIL invalid_sticky got status %h required bit2 set", res_status);
    end
  endtask

  task automatic test_rounding();
    ops[0] = 32'h3F800000;
    ops[1] = 32'h33800000;
    do_run(2, 3'd0, -1, 0, 0);
    checks++;
    if (res_data !== 32'h3F800000 || res_status !== 8'h20) begin
      errors++;
      $display("FAIL round_rne got %h/%h required 3f800000/20",
               res_data, res_status);
    end
    do_run(2, 3'd2, -1, 0, 0);
    checks++;
    if (res_data !== 32'h3F800001 || res_status !== 8'h20) begin
      errors++;
      $display("FAIL round_up got %h/%h required 3f800001/20",
               res_data, res_status);
    end
    ops[2] = 32'h33800000;
    do_run(3, 3'd0, -1, 0, 0);
    checks++;
    if (res_data !== 32'h3F800001 || res_status !== 8'h00) begin
      errors++;
      $display("FAIL round_exact got %h/%h required 3f800001/00",
               res_data, res_status);
    end
  endtask

  task automatic test_cancel_and_sign();
    ops[0] = 32'h3F800000;
    ops[1] = 32'hBF800000;
    do_run(2, 3'd0, -1, 0, 0);
    checks++;
    if (res_data !== 32'h00000000 || res_status !== 8'h01) begin
      errors++;
      $display("FAIL cancel_rne got %h/%h required 00000000/01",
               res_data, res_status);
    end
    do_run(2, 3'd3, -1, 0, 0);
    checks++;
    if (res_data !== 32'h80000000 || res_status !== 8'h01) begin
      errors++;
      $display("FAIL cancel_down got %h/%h required 80000000/01",
               res_data, res_status);
    end
    ops[0] = 32'hBF800000;
    ops[1] = 32'hC0000000;
    ops[2] = 32'h3F800000;
    do_run(3, 3'd0, -1, 0, 0);
    checks++;
    if (res_data !== 32'hC0000000 || res_status !== 8'h00) begin
      errors++;
      $display("FAIL negative got %h/%h required c0000000/00",
               res_data, res_status);
    end
  endtask

  task automatic test_overflow();
    ops[0] = 32'h7F7FFFFF;
    ops[1] = 32'h7F7FFFFF;
    do_run(2, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 4) begin
      errors++;
      $display("FAIL ovf_latency got %0d required 4", res_lat);
    end
    checks++;
    if (res_data !== 32'h7F800000 || res_status !== 8'h32) begin
      errors++;
      $display("FAIL ovf_result got %h/%h required 7f800000/32",
               res_data, res_status);
    end
  endtask

  task automatic test_gap();
    ops[0] = 32'h3F800000;
    ops[1] = 32'h40000000;
    ops[2] = 32'h40400000;
    do_run(3, 3'd0, 2, 0, 0);
    checks++;
    if (res_lat !== 6 || res_data !== 32'h40C00000) begin
      errors++;
      $display("FAIL gap_run got lat=%0d data=%h required 6/40c00000",
               res_lat, res_data);
    end
  endtask

  task automatic test_done_hold();
    ops[0] = 32'h3F800000;
    ops[1] = 32'h40000000;
    ops[2] = 32'h40400000;
    do_run(3, 3'd0, -1, 1, 0);
    checks++;
    if (res_lat !== 5 || res_data !== 32'h40C00000) begin
      errors++;
      $display("FAIL hold_first got lat=%0d data=%h required 5/40c00000",
               res_lat, res_data);
    end
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      len = 8'd3;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h40C00000 ||
          out_status !== 8'h00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable k=%0d got v=%b d=%h s=%h b=%b required 1/40c00000/00/1",
                 k, out_valid, out_data, out_status, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got busy=%b out_valid=%b required 0/0",
               busy, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored got busy=%b required 0", busy);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 255; i++) ops[i] = 32'h3F800000;
    do_run(255, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 341) begin
      errors++;
      $display("FAIL maxlen_latency got %0d required 341", res_lat);
    end
    checks++;
    if (res_data !== 32'h437F0000 || res_status !== 8'h00) begin
      errors++;
      $display("FAIL maxlen_result got %h/%h required 437f0000/00",
               res_data, res_status);
    end
  endtask

  task automatic test_reset_midrun();
    int  idx;
    int  c;
    bit  pend;
    idx = 0;
    c = 0;
    start = 1'b1;
    len = 8'd6;
    rnd = 3'd0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (idx < 2 && c < 20) begin
      pend = in_valid && in_ready;
      @(posedge clk);
      #1;
      c++;
      start = 1'b0;
      if (pend) idx++;
      in_valid = 1'b1;
      in_data = 32'h40800000;
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || idx != 2) begin
      errors++;
      $display("FAIL midrun_setup got busy=%b beats=%0d required 1/2", busy, idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b in_ready=%b out_valid=%b required 000",
               busy, in_ready, out_valid);
    end
    checks++;
    if (out_data !== 32'h0 || out_status !== 8'h00) begin
      errors++;
      $display("FAIL midrun_clear got %h/%h required 00000000/00",
               out_data, out_status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ops[0] = 32'h3F800000;
    ops[1] = 32'h40000000;
    ops[2] = 32'h40400000;
    do_run(3, 3'd0, -1, 0, 0);
    checks++;
    if (res_lat !== 5 || res_data !== 32'h40C00000 || res_status !== 8'h00) begin
      errors++;
      $display("FAIL midrun_fresh got lat=%0d %h/%h required 5/40c00000/00",
               res_lat, res_data, res_status);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_sum3();
    test_padded_groups();
    test_len_zero();
    test_invalid_sticky();
    test_rounding();
    test_cancel_and_sign();
    test_overflow();
    test_gap();
    test_done_hold();
    test_max_len();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
